opb_sw_reg_bank: RTL
====================

OPB_SW_REG_BANK -- requirements
Module: opb_sw_reg_bank

Interface
REQ-001 Parameters (name, default, meaning): C_BASEADDR, 32'h0, first byte address; C_HIGHADDR, 32'hFF, last byte address (inclusive); C_OPB_AWIDTH, 32, address width; C_OPB_DWIDTH, 32, data width (fixed 32); NUM_RW, 4, read/write registers (1..16); NUM_RO, 2, read-only registers (1..16).
REQ-002 Ports (name, direction, width, meaning): OPB_Clk in 1 clock; OPB_Rst_n in 1 reset, asynchronous, active-low; OPB_ABus in [0:31] address; OPB_BE in [0:3] byte enables; OPB_DBus in [0:31] write data; OPB_RNW in 1 read-not-write; OPB_select in 1 slave select; OPB_seqAddr in 1 sequential hint (ignored).
REQ-003 Ports continued: Sl_DBus out [0:31] read data; Sl_xferAck out 1; Sl_errAck out 1; Sl_retry out 1 (tied 0); Sl_toutSup out 1 (tied 0).
REQ-004 User ports: rw_regs out [NUM_RW*32-1:0] (reg k at bits [32k+31:32k]); rw_wr_strobe out [NUM_RW-1:0]; ro_regs in [NUM_RO*32-1:0]; event_in in [31:0]; irq out 1.

Function
REQ-005 Word index = (OPB_ABus - C_BASEADDR) >> 2; hit = OPB_select and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
REQ-006 Map: index 0..NUM_RW-1 RW regs; NUM_RW..NUM_RW+NUM_RO-1 RO regs; NUM_RW+NUM_RO = STICKY; +1 = MASK; any higher index = unmapped.
REQ-007 FSM states IDLE, ACK, GAP: IDLE->ACK on hit; ACK->GAP unconditionally; GAP->IDLE unconditionally; one transfer per 3 cycles max.
REQ-008 Sl_xferAck high for exactly the one cycle in ACK for mapped index; Sl_errAck high instead for unmapped index; never both.
REQ-009 Access decoded and write committed on the IDLE->ACK edge; write data and BE sampled there.
REQ-010 Byte lanes big-endian: BE[0] -> OPB_DBus[0:7] -> reg bits [31:24]; BE[3] -> OPB_DBus[24:31] -> bits [7:0]; unenabled bytes unchanged.
REQ-011 RW write: rw_wr_strobe[k] pulses high for one cycle, coincident with Sl_xferAck, for any write to reg k (even if all BE zero).
REQ-012 RO register writes: acked, no effect.
REQ-013 Read data registered at IDLE->ACK; Sl_DBus valid only while Sl_xferAck high, 32'h0 in all other cycles including errAck cycles.
REQ-014 STICKY: bit i set on any cycle event_in[i]=1; cleared by write-1 on enabled byte lanes; same-cycle set and clear -> set wins.
REQ-015 MASK: plain RW register, byte-enabled.
REQ-016 irq = registered OR of (STICKY & MASK), one-cycle latency from STICKY/MASK update.
REQ-017 OPB_select dropped while in ACK or GAP: FSM still completes to IDLE; no extra ack.

Reset
REQ-018 OPB_Rst_n low asynchronously forces: FSM IDLE, all RW regs, STICKY, MASK = 0, Sl_xferAck, Sl_errAck, rw_wr_strobe, irq = 0, Sl_DBus = 0.
REQ-019 Reset asserted mid-transfer aborts it; no ack issued after release until a new hit.
REQ-020 Reset deassertion synchronised externally; block samples first hit on first clock with OPB_Rst_n high.

Structure
REQ-021 Shared package opb_sw_reg_pkg holds FSM state encoding, word-size constant (4), and index offset functions for STICKY/MASK.
REQ-022 One sub-module opb_byte_en_merge: combinational merge of old value, new data, BE[0:3] per REQ-010; reused for RW, MASK, and W1C mask generation.

Verification
REQ-023 Write 32'hDEADBEEF, BE=4'b1111, to C_BASEADDR+4 -> ack one cycle later, rw_regs[63:32]=32'hDEADBEEF, rw_wr_strobe=4'b0010 for one cycle.
REQ-024 Write 32'h00001234, BE=4'b0011, to reg 0 holding 32'hAAAAAAAA -> reg 0 = 32'hAAAA1234; read back Sl_DBus=32'hAAAA1234 only in ack cycle, 0 otherwise.
REQ-025 Read C_BASEADDR+0x40 with NUM_RW=4, NUM_RO=2 -> Sl_errAck one cycle, Sl_xferAck 0, Sl_DBus 0, no register changes.
REQ-026 event_in[5] pulse, MASK=32'h20 -> STICKY=32'h20, irq=1 next cycle; write 32'h20 to STICKY with event_in[5]=1 same cycle -> STICKY stays 32'h20; repeat with event_in=0 -> STICKY=0, irq=0.
REQ-027 OPB_select held high 6 cycles on one address -> exactly 2 acks, 3 cycles apart.
REQ-028 Assert OPB_Rst_n low between select and ack -> no ack, all outputs 0 immediately (before next clock edge).

Source files
------------

// File: rtl/opb_sw_reg_pkg.sv
// Shared definitions for the OPB software register bank: FSM encoding,
// bus word size and the index helpers for the STICKY/MASK slots.
package opb_sw_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } opb_state_e;

  localparam int unsigned WORD_BYTES = 4;

  // STICKY sits directly after the RW and RO blocks
  function automatic int unsigned sticky_idx(input int unsigned nrw, input int unsigned nro);
    return nrw + nro;
  endfunction

  // MASK follows STICKY
  function automatic int unsigned mask_idx(input int unsigned nrw, input int unsigned nro);
    return nrw + nro + 1;
  endfunction

endpackage

// File: rtl/opb_sw_reg_bank_if.sv
// OPB slave-side bus bundle. Bit 0 is the MSB on every vector, as on OPB.
interface opb_sw_reg_bank_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_byte_en_merge.sv
// Byte-enable merge: BE[0] selects the most significant byte (big-endian lanes).
module opb_byte_en_merge
  import opb_sw_reg_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [0:3]  be_i,
  output logic [31:0] merged_o
);

  // Replace each enabled byte lane, keep the rest
  always_comb begin
    merged_o = old_i;
    for (int j = 0; j < WORD_BYTES; j++) begin
      if (be_i[j]) merged_o[31-8*j -: 8] = new_i[31-8*j -: 8];
    end
  end

endmodule

// File: rtl/opb_sw_reg_bank.sv
// OPB slave register bank: NUM_RW read/write regs, NUM_RO read-only inputs,
// a sticky event register with write-1-to-clear, an interrupt mask and irq.
// Transfers take three cycles: decode/commit, ack, gap.
module opb_sw_reg_bank
  import opb_sw_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0,
  parameter logic [31:0] C_HIGHADDR   = 32'hFF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter int unsigned NUM_RW       = 4,
  parameter int unsigned NUM_RO       = 2
) (
  input  logic                   OPB_Clk,
  input  logic                   OPB_Rst_n,
  opb_sw_reg_bank_if.slave       bus,
  output logic [NUM_RW*32-1:0]   rw_regs,
  output logic [NUM_RW-1:0]      rw_wr_strobe,
  input  logic [NUM_RO*32-1:0]   ro_regs,
  input  logic [31:0]            event_in,
  output logic                   irq
);

  localparam int unsigned STICKY_IDX = sticky_idx(NUM_RW, NUM_RO);
  localparam int unsigned MASK_IDX   = mask_idx(NUM_RW, NUM_RO);
  localparam logic [C_OPB_AWIDTH-1:0] SPAN = C_OPB_AWIDTH'(C_HIGHADDR - C_BASEADDR);

  opb_state_e                state_q;
  logic [NUM_RW-1:0][31:0]   rw_q, rw_d, rw_merged;
  logic [31:0]               sticky_q, sticky_d, mask_q, mask_d, mask_merged;
  logic [31:0]               w1c_bits, sticky_clr, rd_data, dbus_q;
  logic                      xfer_ack_q, err_ack_q, irq_q;
  logic [NUM_RW-1:0]         strobe_q, wr_sel;

  logic [C_OPB_AWIDTH-1:0]   addr, off, idx;
  logic [C_OPB_DWIDTH-1:0]   wdata;
  logic                      hit, mapped, wr;
  logic                      unused_seq;

  // Offset from base; an address below base wraps above SPAN and misses
  assign addr       = bus.OPB_ABus;
  assign wdata      = bus.OPB_DBus;
  assign off        = addr - C_OPB_AWIDTH'(C_BASEADDR);
  assign idx        = off >> $clog2(WORD_BYTES);
  assign hit        = bus.OPB_select && (off <= SPAN);
  assign mapped     = idx <= C_OPB_AWIDTH'(MASK_IDX);
  assign wr         = (state_q == ST_IDLE) && hit && mapped && !bus.OPB_RNW;
  assign unused_seq = bus.OPB_seqAddr;

  // Byte-lane merges: one per RW register, one for MASK, one for W1C bits
  for (genvar k = 0; k < NUM_RW; k++) begin : g_rw
    opb_byte_en_merge u_merge (
      .old_i    (rw_q[k]),
      .new_i    (wdata),
      .be_i     (bus.OPB_BE),
      .merged_o (rw_merged[k])
    );
  end

  opb_byte_en_merge u_mask_merge (
    .old_i    (mask_q),
    .new_i    (wdata),
    .be_i     (bus.OPB_BE),
    .merged_o (mask_merged)
  );

  opb_byte_en_merge u_w1c_merge (
    .old_i    (32'h0),
    .new_i    (wdata),
    .be_i     (bus.OPB_BE),
    .merged_o (w1c_bits)
  );

  // Write decode and next-state for the writable registers
  always_comb begin
    wr_sel = '0;
    rw_d   = rw_q;
    for (int k = 0; k < NUM_RW; k++) begin
      if (wr && idx == C_OPB_AWIDTH'(k)) begin
        wr_sel[k] = 1'b1;
        rw_d[k]   = rw_merged[k];
      end
    end
    mask_d     = (wr && idx == C_OPB_AWIDTH'(MASK_IDX)) ? mask_merged : mask_q;
    sticky_clr = (wr && idx == C_OPB_AWIDTH'(STICKY_IDX)) ? w1c_bits : 32'h0;
    // event set is applied after the clear so a simultaneous set wins
    sticky_d   = (sticky_q & ~sticky_clr) | event_in;
  end

  // Read mux over the whole map; unmapped indices read as zero
  always_comb begin
    rd_data = 32'h0;
    for (int k = 0; k < NUM_RW; k++)
      if (idx == C_OPB_AWIDTH'(k)) rd_data = rw_q[k];
    for (int k = 0; k < NUM_RO; k++)
      if (idx == C_OPB_AWIDTH'(NUM_RW + k)) rd_data = ro_regs[32*k +: 32];
    if (idx == C_OPB_AWIDTH'(STICKY_IDX)) rd_data = sticky_q;
    if (idx == C_OPB_AWIDTH'(MASK_IDX))   rd_data = mask_q;
  end

  // Transfer FSM with registered ack, read data and strobes
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q    <= ST_IDLE;
      xfer_ack_q <= 1'b0;
      err_ack_q  <= 1'b0;
      dbus_q     <= 32'h0;
      strobe_q   <= '0;
    end else begin
      xfer_ack_q <= 1'b0;
      err_ack_q  <= 1'b0;
      dbus_q     <= 32'h0;
      strobe_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            state_q    <= ST_ACK;
            xfer_ack_q <= mapped;
            err_ack_q  <= !mapped;
            strobe_q   <= wr_sel;
            if (mapped && bus.OPB_RNW) dbus_q <= rd_data;
          end
        end
        ST_ACK:  state_q <= ST_GAP;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Register storage and irq, which lags STICKY/MASK by one cycle
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      rw_q     <= '0;
      mask_q   <= 32'h0;
      sticky_q <= 32'h0;
      irq_q    <= 1'b0;
    end else begin
      rw_q     <= rw_d;
      mask_q   <= mask_d;
      sticky_q <= sticky_d;
      irq_q    <= |(sticky_q & mask_q);
    end
  end

  assign bus.Sl_DBus    = dbus_q;
  assign bus.Sl_xferAck = xfer_ack_q;
  assign bus.Sl_errAck  = err_ack_q;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;
  assign rw_regs        = rw_q;
  assign rw_wr_strobe   = strobe_q;
  assign irq            = irq_q;

endmodule
